// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    localparam int unsigned AluCtrlW = 4;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StJalrLink,
        StLui,
        StAuipc,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct,
        AluOpPassB
    } aluop_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [AluCtrlW-1:0] AluAdd   = 4'b0000;
    localparam logic [AluCtrlW-1:0] AluSub   = 4'b0001;
    localparam logic [AluCtrlW-1:0] AluAnd   = 4'b0010;
    localparam logic [AluCtrlW-1:0] AluOr    = 4'b0011;
    localparam logic [AluCtrlW-1:0] AluPassB = 4'b0100;
    localparam logic [AluCtrlW-1:0] AluSlt   = 4'b0101;
    localparam logic [AluCtrlW-1:0] AluSll   = 4'b0110;
    localparam logic [AluCtrlW-1:0] AluSltu  = 4'b0111;
    localparam logic [AluCtrlW-1:0] AluXor   = 4'b1000;
    localparam logic [AluCtrlW-1:0] AluSrl   = 4'b1001;
    localparam logic [AluCtrlW-1:0] AluSra   = 4'b1010;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmB = 3'b001;
    localparam logic [2:0] ImmS = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    // funct3 010/011 are not branches; callers trap on those before using this.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the FSM's coarse aluop plus the
// instruction's funct3, bit 30 and opcode bit 5 (R-type vs I-type).
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e              aluop,
    input  logic [2:0]          funct3,
    input  logic                funct7,
    input  logic                op5,
    output logic [AluCtrlW-1:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = AluAdd;
        case (aluop)
            AluOpAdd:   alu_ctrl = AluAdd;
            AluOpSub:   alu_ctrl = AluSub;
            AluOpPassB: alu_ctrl = AluPassB;
            AluOpFunct: begin
                case (funct3)
                    // Bit 30 is an immediate bit for addi, so SUB needs the R-type opcode.
                    3'b000:  alu_ctrl = (op5 && funct7) ? AluSub : AluAdd;
                    3'b001:  alu_ctrl = AluSll;
                    3'b010:  alu_ctrl = AluSlt;
                    3'b011:  alu_ctrl = AluSltu;
                    3'b100:  alu_ctrl = AluXor;
                    3'b101:  alu_ctrl = funct7 ? AluSra : AluSrl;
                    3'b110:  alu_ctrl = AluOr;
                    default: alu_ctrl = AluAnd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM with variable-latency memory handshake and illegal-opcode trap.
// Define MULTICYCLE_PERF_COUNTERS_EN to add cycle_cnt_o / instret_o counters.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_i,
    input  logic                  zero_i,
    input  logic                  lt_i,
    input  logic                  ltu_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  MemWrite_o,
    output logic                  AdrSrc_o,
    output logic                  IRWrite_o,
    output logic                  PCWrite_o,
    output logic                  RegWrite_o,
    output logic [1:0]            ALUSrcA_o,
    output logic [1:0]            ALUSrcB_o,
    output logic [ALU_CTRL_W-1:0] ALUControl_o,
    output logic [2:0]            ImmSrc_o,
    output logic [1:0]            ResultSrc_o,
    output logic                  illegal_o
`ifdef MULTICYCLE_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      instret_o
`endif
);

    state_e                state_q, state_d;
    aluop_e                aluop;
    logic                  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]            alu_src_a, alu_src_b, result_src;
    logic [2:0]            imm_src;
    logic [AluCtrlW-1:0]   alu_ctrl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        imm_src    = ImmI;
        result_src = ResAluOut;
        aluop      = AluOpAdd;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Precompute the branch target into ALUOut for the BRANCH state.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = ImmB;
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                imm_src   = (op_i == OpStore) ? ImmS : ImmI;
                state_d   = (op_i == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResMem;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                aluop     = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                aluop     = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                aluop     = AluOpSub;
                if (funct3_i[2:1] == 2'b01) begin
                    state_d = StTrap;
                end else begin
                    pc_write = branch_taken(funct3_i, zero_i, lt_i, ltu_i);
                    state_d  = StFetch;
                end
            end
            StJal: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                pc_write   = 1'b1;
                result_src = ResAlu;
                state_d    = StJalrLink;
            end
            StJalrLink: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                state_d   = StAluWb;
            end
            StLui: begin
                alu_src_b = SrcBImm;
                imm_src   = ImmU;
                aluop     = AluOpPassB;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = ImmU;
                state_d   = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop    (aluop),
        .funct3   (funct3_i),
        .funct7   (funct7_i),
        .op5      (op_i[5]),
        .alu_ctrl (alu_ctrl)
    );

    // Reset holds every control line low so nothing is written while the datapath settles.
    assign mem_req_o    = mem_req   & ~rst_i;
    assign MemWrite_o   = mem_write & ~rst_i;
    assign AdrSrc_o     = adr_src   & ~rst_i;
    assign IRWrite_o    = ir_write  & ~rst_i;
    assign PCWrite_o    = pc_write  & ~rst_i;
    assign RegWrite_o   = reg_write & ~rst_i;
    assign ALUSrcA_o    = rst_i ? 2'b00 : alu_src_a;
    assign ALUSrcB_o    = rst_i ? 2'b00 : alu_src_b;
    assign ALUControl_o = rst_i ? '0 : ALU_CTRL_W'(alu_ctrl);
    assign ImmSrc_o     = rst_i ? 3'b000 : imm_src;
    assign ResultSrc_o  = rst_i ? 2'b00 : result_src;
    assign illegal_o    = (state_q == StTrap) & ~rst_i;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            // Retire on entry to FETCH; the fetch wait loop is not an entry.
            if (state_d == StFetch && state_q != StFetch) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instret_o   = instret_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against a phase-level timing model.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] f3 = 3'b0;
    logic       f7 = 1'b0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] src_a, src_b, res_src;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic [19:0] all_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_i         (op),
        .funct3_i     (f3),
        .funct7_i     (f7),
        .zero_i       (zero),
        .lt_i         (lt),
        .ltu_i        (ltu),
        .mem_ready_i  (mem_ready),
        .mem_req_o    (mem_req),
        .MemWrite_o   (mem_write),
        .AdrSrc_o     (adr_src),
        .IRWrite_o    (ir_write),
        .PCWrite_o    (pc_write),
        .RegWrite_o   (reg_write),
        .ALUSrcA_o    (src_a),
        .ALUSrcB_o    (src_b),
        .ALUControl_o (alu_ctrl),
        .ImmSrc_o     (imm_src),
        .ResultSrc_o  (res_src),
        .illegal_o    (illegal)
    );

    assign all_out = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                      src_a, src_b, alu_ctrl, imm_src, res_src, illegal};

    // Expected per-cycle behaviour of one instruction, built from the ISA-level rules.
    typedef struct packed {
        logic       rdy;
        logic       req;
        logic       ir;
        logic       pc;
        logic       rw;
        logic       mw;
        logic       chk_alu;
        logic [3:0] alu;
        logic [1:0] rs;
    } step_t;

    step_t model_q[$];

    function automatic void add_step(input logic rdy, input logic req, input logic ir,
                                     input logic pc, input logic rw, input logic mw,
                                     input logic chk_alu, input logic [3:0] alu,
                                     input logic [1:0] rs);
        step_t s;
        s.rdy = rdy; s.req = req; s.ir = ir; s.pc = pc; s.rw = rw; s.mw = mw;
        s.chk_alu = chk_alu; s.alu = alu; s.rs = rs;
        model_q.push_back(s);
    endfunction

    function automatic logic [3:0] ref_alu(input bit is_r, input logic [2:0] fn3,
                                           input logic fn7);
        case (fn3)
            3'd0: return (is_r && fn7) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0110;
            3'd2: return 4'b0101;
            3'd3: return 4'b0111;
            3'd4: return 4'b1000;
            3'd5: return fn7 ? 4'b1010 : 4'b1001;
            3'd6: return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] fn3, input logic z, input logic l,
                                       input logic lu);
        case (fn3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            default: return !lu;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // cls: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 LUI, 6 AUIPC, 7 JALR
    function automatic void build_model(input int cls, input logic [2:0] fn3, input logic fn7,
                                        input logic z, input logic l, input logic lu,
                                        input int fw, input int dw);
        model_q.delete();
        for (int i = 0; i < fw; i++) add_step(1'b0, 1'b1, 0, 0, 0, 0, 0, 4'b0, 2'b0);
        add_step(1'b1, 1'b1, 1, 1, 0, 0, 1, 4'b0000, 2'b10);
        add_step(rnd(), 0, 0, 0, 0, 0, 1, 4'b0000, 2'b0);
        case (cls)
            0, 1: begin
                add_step(rnd(), 0, 0, 0, 0, 0, 1, ref_alu(cls == 0, fn3, fn7), 2'b0);
                add_step(rnd(), 0, 0, 0, 1, 0, 0, 4'b0, 2'b00);
            end
            2: begin
                add_step(rnd(), 0, 0, 0, 0, 0, 1, 4'b0000, 2'b0);
                for (int i = 0; i < dw; i++) add_step(1'b0, 1, 0, 0, 0, 0, 0, 4'b0, 2'b0);
                add_step(1'b1, 1, 0, 0, 0, 0, 0, 4'b0, 2'b0);
                add_step(rnd(), 0, 0, 0, 1, 0, 0, 4'b0, 2'b01);
            end
            3: begin
                add_step(rnd(), 0, 0, 0, 0, 0, 1, 4'b0000, 2'b0);
                for (int i = 0; i < dw; i++) add_step(1'b0, 1, 0, 0, 0, 1, 0, 4'b0, 2'b0);
                add_step(1'b1, 1, 0, 0, 0, 1, 0, 4'b0, 2'b0);
            end
            4: add_step(rnd(), 0, 0, ref_taken(fn3, z, l, lu), 0, 0, 0, 4'b0, 2'b00);
            5, 6: begin
                add_step(rnd(), 0, 0, 0, 0, 0, 1, (cls == 5) ? 4'b0100 : 4'b0000, 2'b0);
                add_step(rnd(), 0, 0, 0, 1, 0, 0, 4'b0, 2'b00);
            end
            default: begin
                add_step(rnd(), 0, 0, 1, 0, 0, 1, 4'b0000, 2'b10);
                add_step(rnd(), 0, 0, 0, 0, 0, 1, 4'b0000, 2'b0);
                add_step(rnd(), 0, 0, 0, 1, 0, 0, 4'b0, 2'b00);
            end
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 00000", all_out);
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (all_out !== {6'b100000, 2'b00, 2'b10, 4'b0000, 3'b000, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL reset_fetch: got %h", all_out);
        end
    endtask

    task automatic test_add();
        logic [31:0] instr = 32'h002081B3;
        @(negedge clk);
        op = instr[6:0]; f3 = instr[14:12]; f7 = instr[30]; mem_ready = 1'b1;
        #1;
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL add_fetch: ir=%b pc=%b want 1 1", ir_write, pc_write);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({src_a, src_b, imm_src} !== {2'b01, 2'b01, 3'b001}) begin
            errors++;
            $display("FAIL add_decode: srcA=%b srcB=%b imm=%b", src_a, src_b, imm_src);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({alu_ctrl, src_a, src_b} !== {4'b0000, 2'b10, 2'b00} || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: alu=%b srcA=%b srcB=%b rw=%b", alu_ctrl, src_a, src_b,
                     reg_write);
        end
        @(negedge clk);
        #1;
        checks++;
        if (reg_write !== 1'b1 || res_src !== 2'b00) begin
            errors++;
            $display("FAIL add_wb: rw=%b rs=%b want 1 00", reg_write, res_src);
        end
    endtask

    task automatic test_shift_imm();
        logic [2:0] fn3s[2] = '{3'b101, 3'b000};
        logic [3:0] exp[2]  = '{4'b1010, 4'b0000};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op = 7'b0010011; f3 = fn3s[k]; f7 = 1'b1; mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (alu_ctrl !== exp[k] || src_b !== 2'b01) begin
                errors++;
                $display("FAIL itype_alu[%0d]: alu=%b want %b srcB=%b", k, alu_ctrl, exp[k],
                         src_b);
            end
            @(negedge clk);
            #1;
            checks++;
            if (reg_write !== 1'b1) begin
                errors++;
                $display("FAIL itype_wb[%0d]: rw=%b want 1", k, reg_write);
            end
        end
    endtask

    task automatic test_branch();
        // {funct3, zero, lt, ltu, expected PCWrite}
        logic [6:0] cases[4] = '{{3'b001, 3'b100, 1'b0}, {3'b001, 3'b000, 1'b1},
                                 {3'b110, 3'b110, 1'b0}, {3'b110, 3'b001, 1'b1}};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            op = 7'b1100011; f3 = cases[k][6:4];
            {zero, lt, ltu} = cases[k][3:1]; mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (pc_write !== cases[k][0] || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL branch[%0d]: pc=%b want %b rw=%b", k, pc_write, cases[k][0],
                         reg_write);
            end
        end
    endtask

    task automatic test_jal();
        int rw_seen = 0;
        bit back = 0;
        @(negedge clk);
        op = 7'b1101111; f3 = 3'b0; f7 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pc_write !== 1'b1 || res_src !== 2'b00 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL jal_jump: pc=%b rs=%b rw=%b want 1 00 0", pc_write, res_src,
                     reg_write);
        end
        for (int i = 0; i < 4 && !back; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (mem_req) back = 1;
            else if (reg_write) rw_seen++;
        end
        checks++;
        if (!back || rw_seen != 1) begin
            errors++;
            $display("FAIL jal_link: back=%0d writes=%0d want 1 1", back, rw_seen);
        end
    endtask

    task automatic test_load_wait();
        int held = 0;
        int wb = 0;
        bit back = 0;
        @(negedge clk);
        op = 7'b0000011; f3 = 3'b010; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            if (mem_req && adr_src && !mem_write && !reg_write) held++;
        end
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL load_hold: memread cycles=%0d want 4", held);
        end
        for (int i = 0; i < 4 && !back; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (mem_req) back = 1;
            else if (reg_write && res_src == 2'b01) wb++;
        end
        checks++;
        if (!back || wb != 1) begin
            errors++;
            $display("FAIL load_wb: back=%0d writes=%0d want 1 1", back, wb);
        end
    endtask

    task automatic test_random();
        int cls, fw, dw;
        logic [2:0] fn3;
        logic fn7, z, l, lu;
        logic [6:0] ops[8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b0010111, 7'b1100111};
        logic [2:0] br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 7);
            fn3 = (cls == 4) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            fn7 = rnd(); z = rnd(); l = rnd(); lu = rnd();
            fw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            build_model(cls, fn3, fn7, z, l, lu, fw, dw);
            for (int k = 0; k < model_q.size(); k++) begin
                @(negedge clk);
                if (k == 0) begin
                    op = ops[cls]; f3 = fn3; f7 = fn7; zero = z; lt = l; ltu = lu;
                end
                mem_ready = model_q[k].rdy;
                #1;
                checks++;
                if ({mem_req, ir_write, pc_write, reg_write, mem_write, illegal} !==
                    {model_q[k].req, model_q[k].ir, model_q[k].pc, model_q[k].rw,
                     model_q[k].mw, 1'b0}) begin
                    errors++;
                    $display("FAIL rand[%0d] cls%0d cyc%0d ctrl: got %b want %b", n, cls, k,
                             {mem_req, ir_write, pc_write, reg_write, mem_write, illegal},
                             {model_q[k].req, model_q[k].ir, model_q[k].pc, model_q[k].rw,
                              model_q[k].mw, 1'b0});
                end
                if (model_q[k].chk_alu) begin
                    checks++;
                    if (alu_ctrl !== model_q[k].alu) begin
                        errors++;
                        $display("FAIL rand[%0d] cls%0d cyc%0d alu: got %b want %b", n, cls,
                                 k, alu_ctrl, model_q[k].alu);
                    end
                end
                if (model_q[k].rw || model_q[k].pc) begin
                    checks++;
                    if (res_src !== model_q[k].rs) begin
                        errors++;
                        $display("FAIL rand[%0d] cls%0d cyc%0d resultsrc: got %b want %b", n,
                                 cls, k, res_src, model_q[k].rs);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_memread();
        @(negedge clk);
        op = 7'b0000011; f3 = 3'b010; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || adr_src !== 1'b1) begin
            errors++;
            $display("FAIL mid_memread: req=%b adr=%b want 1 1", mem_req, adr_src);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h want 00000", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req, adr_src, reg_write, mem_write} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset_fetch: req/adr/rw/mw=%b want 1000",
                     {mem_req, adr_src, reg_write, mem_write});
        end
    endtask

    task automatic test_trap();
        @(negedge clk);
        op = 7'h7F; f3 = 3'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = rnd();
            #1;
            checks++;
            if (all_out !== 20'h1) begin
                errors++;
                $display("FAIL trap_hold[%0d]: got %h want 00001", i, all_out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset: illegal=%b req=%b want 0 0", illegal, mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        op = 7'b1100011; f3 = 3'b010;
        #1;
        checks++;
        if (illegal !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL trap_clear: illegal=%b req=%b want 0 1", illegal, mem_req);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pc_write !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL bad_branch: pc=%b illegal=%b want 0 0", pc_write, illegal);
        end
        @(negedge clk);
        #1;
        checks++;
        if (all_out !== 20'h1) begin
            errors++;
            $display("FAIL bad_branch_trap: got %h want 00001", all_out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_imm();
        test_branch();
        test_jal();
        test_load_wait();
        test_random();
        test_reset_mid_memread();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
